piece_controller: RTL
=====================

// Module: piece_controller
// PURPOSE
//  Owns the active falling tetromino and issues move requests to block_settling.
//  Proposes next coordinates (x*_next_out/y*_next_out with movement), commits the
//  collision-checked changed_* result, and spawns a new LFSR-chosen piece when
//  block_settling locks the current one. Stops on game_over_logic.
// PARAMETERS
//  LFSR_SEED  8'hA5  non-zero reset seed of the piece-type LFSR
// PORTS
//  clk                     in   1  system clock
//  reset                   in   1  synchronous, active-high reset
//  ce                      in   1  gravity tick, 1-cycle pulse (same ce as block_settling)
//  start                   in   1  pulse: leave IDLE and spawn first piece
//  btn_left/btn_right      in   1  1-cycle pulses: shift piece one column
//  btn_rot/btn_down        in   1  1-cycle pulses: rotate clockwise / soft-drop one row
//  block_logic_reset       in   1  from block_settling: high = current piece locked
//  game_over_logic         in   1  from block_settling: row 2 cols 3..6 occupied
//  changed_x1..x4          in   4  collision-checked x from block_settling
//  changed_y1..y4          in   5  collision-checked y from block_settling
//  x1..x4 / y1..y4         out  4/5  committed piece cells (registered)
//  x1_next_out..x4_next_out out 4  proposed x (combinational)
//  y1_next_out..y4_next_out out 5  proposed y (combinational)
//  movement                out  3  0 hold, 1 down, 2 rotate, 3 left, 4 right
//  block_type              out  3  active piece type 1..7 (0 = none)
//  next_type               out  3  preview type 1..7
//  game_over               out  1  high in OVER state
// BEHAVIOUR
//  Reset: state IDLE; x*,y*=0; block_type=0; game_over=0; lfsr=LFSR_SEED;
//   next_type from seed; lock-edge register cleared.
//  LFSR: 8-bit Fibonacci, taps 8,6,5,4, steps every clk incl. IDLE;
//   candidate type = lfsr[2:0], 0 maps to 1.
//  Types/spawn (x,y), cell2 = pivot: 1 J (3,0)(4,0)(5,0)(5,1); 2 O (4,0)(5,0)(4,1)(5,1);
//   3 T (3,0)(4,0)(5,0)(4,1); 4 S (5,0)(4,0)(4,1)(3,1); 5 L (3,0)(4,0)(5,0)(3,1);
//   6 Z (3,0)(4,0)(4,1)(5,1); 7 I (3,0)(4,0)(5,0)(6,0).
//  FSM: IDLE -start-> SPAWN; SPAWN (1 cycle): load spawn cells of next_type,
//   block_type<=next_type, next_type<=new candidate -> FALL.
//   FALL: on lock = block_logic_reset & ~prev -> CHECK; CHECK: game_over_logic ? OVER : SPAWN.
//   OVER: game_over=1, outputs frozen until reset.
//  Request select in FALL (one per cycle): ce > btn_down > btn_rot > btn_left > btn_right;
//   losers are dropped, not queued. Outside FALL or when no request: movement=0.
//  next_out: hold = current; down = y+1 (may reach 20, the floor row);
//   left = x-1 unless any x==0, then current; right = x+1 unless any x==9, then current;
//   rotate = xi'=px-(yi-py), yi'=py+(xi-px) with signed 6-bit math, unchanged if type 2
//   or any result outside x 0..9 / y 0..19.
//  Commit: in a FALL cycle with movement!=0, x*,y* <= changed_* at next edge (latency 1).
//  Lock cycle: ce commit and lock edge never coincide (lock is 1 cycle after ce); commit
//   suppressed in CHECK/SPAWN/OVER.
//  Mid-operation reset returns to IDLE with reset values in one cycle.
// TESTING
//  reset, start, LFSR fixed so next_type=7 -> after 2 cycles x=3,4,5,6 y=0 block_type=7.
//  FALL, btn_left x4 from I at x 3..6 -> x=0..3; 5th press -> x_next_out=current, no change.
//  ce and btn_right same cycle -> movement=1, y +1, x unchanged.
//  T at (3,0)(4,0)(5,0)(4,1), btn_rot -> next_out (4,-1) out of range -> no change; after 2 ce -> rotates to (4,1)(4,2)(4,3)(3,2).
//  block_logic_reset held high 3 cycles -> exactly one SPAWN; game_over_logic=1 in CHECK -> OVER, game_over=1, buttons ignored.

Source files
------------

// File: rtl/piece_if.sv
// piece_if: the signal bundle between piece_controller and its environment
// (block_settling, the input buttons and the gravity tick).
//
// Handshake: piece_controller presents a request as movement != 0 together
// with the proposed cells on *_next_out. block_settling answers in the same
// cycle with changed_*, the collision-checked version of that proposal. The
// controller commits changed_* on the next rising edge. There is no ready or
// back-pressure; a request that is not selected in its cycle is lost.
//
// Modports:
//   master : piece_controller side (buttons/feedback in, piece state out)
//   slave  : environment side (drives buttons/feedback, observes piece state)
interface piece_if;
  logic       ce;
  logic       start;
  logic       btn_left;
  logic       btn_right;
  logic       btn_rot;
  logic       btn_down;
  logic       block_logic_reset;
  logic       game_over_logic;
  logic [3:0] changed_x1, changed_x2, changed_x3, changed_x4;
  logic [4:0] changed_y1, changed_y2, changed_y3, changed_y4;
  logic [3:0] x1, x2, x3, x4;
  logic [4:0] y1, y2, y3, y4;
  logic [3:0] x1_next_out, x2_next_out, x3_next_out, x4_next_out;
  logic [4:0] y1_next_out, y2_next_out, y3_next_out, y4_next_out;
  logic [2:0] movement;
  logic [2:0] block_type;
  logic [2:0] next_type;
  logic       game_over;

  modport master (
    input  ce, start, btn_left, btn_right, btn_rot, btn_down,
           block_logic_reset, game_over_logic,
           changed_x1, changed_x2, changed_x3, changed_x4,
           changed_y1, changed_y2, changed_y3, changed_y4,
    output x1, x2, x3, x4, y1, y2, y3, y4,
           x1_next_out, x2_next_out, x3_next_out, x4_next_out,
           y1_next_out, y2_next_out, y3_next_out, y4_next_out,
           movement, block_type, next_type, game_over
  );

  modport slave (
    output ce, start, btn_left, btn_right, btn_rot, btn_down,
           block_logic_reset, game_over_logic,
           changed_x1, changed_x2, changed_x3, changed_x4,
           changed_y1, changed_y2, changed_y3, changed_y4,
    input  x1, x2, x3, x4, y1, y2, y3, y4,
           x1_next_out, x2_next_out, x3_next_out, x4_next_out,
           y1_next_out, y2_next_out, y3_next_out, y4_next_out,
           movement, block_type, next_type, game_over
  );
endinterface

// File: rtl/piece_controller.sv
// piece_controller: owns the active falling tetromino.
//  - Proposes the next cell coordinates for one movement per cycle
//    (gravity, soft drop, rotate, left, right) on bus.*_next_out.
//  - Commits block_settling's collision-checked bus.changed_* one edge later.
//  - Spawns a new piece, chosen by an 8-bit LFSR, each time block_settling
//    locks the current one; stops in OVER when game_over_logic is seen.
// Ports:
//   clk        system clock
//   reset      synchronous, active-high
//   bus        piece_if.master (buttons, block_settling feedback, piece state)
//   dbg_state  current FSM state (0 IDLE, 1 SPAWN, 2 FALL, 3 CHECK, 4 OVER)
module piece_controller #(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  piece_if.master    bus,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_FALL  = 3'd2,
    S_CHECK = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [2:0] MV_HOLD  = 3'd0;
  localparam logic [2:0] MV_DOWN  = 3'd1;
  localparam logic [2:0] MV_ROT   = 3'd2;
  localparam logic [2:0] MV_LEFT  = 3'd3;
  localparam logic [2:0] MV_RIGHT = 3'd4;

  // Piece type 0 is "no piece"; an LFSR value of 0 in the low bits becomes J.
  function automatic logic [2:0] to_type(input logic [2:0] v);
    return (v == 3'd0) ? 3'd1 : v;
  endfunction

  state_t     state, state_nx;
  logic [7:0] lfsr;
  logic       lfsr_fb;
  logic [2:0] cand_type;
  logic       lock_prev;
  logic       lock;
  logic [2:0] block_type;
  logic [2:0] next_type;
  logic [2:0] mv;

  // Cell arrays; index 1 is the rotation pivot.
  logic [3:0] cur_x [4];
  logic [4:0] cur_y [4];
  logic [3:0] nxt_x [4];
  logic [4:0] nxt_y [4];
  logic [3:0] spn_x [4];
  logic [4:0] spn_y [4];
  logic [3:0] chg_x [4];
  logic [4:0] chg_y [4];

  logic signed [5:0] piv_x, piv_y;
  logic signed [5:0] rot_x [4];
  logic signed [5:0] rot_y [4];
  logic              rot_ok;
  logic              at_left, at_right;

  // ---------------------------------------------------------------------
  // Interface mapping
  // ---------------------------------------------------------------------
  assign chg_x[0] = bus.changed_x1;
  assign chg_x[1] = bus.changed_x2;
  assign chg_x[2] = bus.changed_x3;
  assign chg_x[3] = bus.changed_x4;
  assign chg_y[0] = bus.changed_y1;
  assign chg_y[1] = bus.changed_y2;
  assign chg_y[2] = bus.changed_y3;
  assign chg_y[3] = bus.changed_y4;

  assign bus.x1 = cur_x[0];
  assign bus.x2 = cur_x[1];
  assign bus.x3 = cur_x[2];
  assign bus.x4 = cur_x[3];
  assign bus.y1 = cur_y[0];
  assign bus.y2 = cur_y[1];
  assign bus.y3 = cur_y[2];
  assign bus.y4 = cur_y[3];

  assign bus.x1_next_out = nxt_x[0];
  assign bus.x2_next_out = nxt_x[1];
  assign bus.x3_next_out = nxt_x[2];
  assign bus.x4_next_out = nxt_x[3];
  assign bus.y1_next_out = nxt_y[0];
  assign bus.y2_next_out = nxt_y[1];
  assign bus.y3_next_out = nxt_y[2];
  assign bus.y4_next_out = nxt_y[3];

  assign bus.movement   = mv;
  assign bus.block_type = block_type;
  assign bus.next_type  = next_type;

  // ---------------------------------------------------------------------
  // Piece-type LFSR: Fibonacci, taps 8,6,5,4; free-running in every state
  // so the piece sequence depends on when the player presses start.
  // ---------------------------------------------------------------------
  assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign cand_type = to_type(lfsr[2:0]);

  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[6:0], lfsr_fb};
  end

  // block_settling holds block_logic_reset for several cycles; only its
  // rising edge counts as a lock.
  always_ff @(posedge clk) begin
    if (reset) lock_prev <= 1'b0;
    else       lock_prev <= bus.block_logic_reset;
  end

  assign lock = bus.block_logic_reset & ~lock_prev;

  // ---------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.start) state_nx = S_SPAWN;
      S_SPAWN: state_nx = S_FALL;
      S_FALL:  if (lock) state_nx = S_CHECK;
      S_CHECK: state_nx = bus.game_over_logic ? S_OVER : S_SPAWN;
      S_OVER:  state_nx = S_OVER;
      default: state_nx = S_IDLE;
    endcase
  end

  // One request per cycle; lower-priority requests in the same cycle are
  // dropped.
  always_comb begin
    mv            = MV_HOLD;
    bus.game_over = (state == S_OVER);
    dbg_state     = state;
    if (state == S_FALL) begin
      if (bus.ce)             mv = MV_DOWN;
      else if (bus.btn_down)  mv = MV_DOWN;
      else if (bus.btn_rot)   mv = MV_ROT;
      else if (bus.btn_left)  mv = MV_LEFT;
      else if (bus.btn_right) mv = MV_RIGHT;
    end
  end

  // ---------------------------------------------------------------------
  // Spawn table for the previewed type
  // ---------------------------------------------------------------------
  always_comb begin
    spn_x = '{4'd3, 4'd4, 4'd5, 4'd6};
    spn_y = '{5'd0, 5'd0, 5'd0, 5'd0};
    case (next_type)
      3'd1: begin spn_x = '{4'd3, 4'd4, 4'd5, 4'd5}; spn_y = '{5'd0, 5'd0, 5'd0, 5'd1}; end
      3'd2: begin spn_x = '{4'd4, 4'd5, 4'd4, 4'd5}; spn_y = '{5'd0, 5'd0, 5'd1, 5'd1}; end
      3'd3: begin spn_x = '{4'd3, 4'd4, 4'd5, 4'd4}; spn_y = '{5'd0, 5'd0, 5'd0, 5'd1}; end
      3'd4: begin spn_x = '{4'd5, 4'd4, 4'd4, 4'd3}; spn_y = '{5'd0, 5'd0, 5'd1, 5'd1}; end
      3'd5: begin spn_x = '{4'd3, 4'd4, 4'd5, 4'd3}; spn_y = '{5'd0, 5'd0, 5'd0, 5'd1}; end
      3'd6: begin spn_x = '{4'd3, 4'd4, 4'd4, 4'd5}; spn_y = '{5'd0, 5'd0, 5'd1, 5'd1}; end
      default: begin spn_x = '{4'd3, 4'd4, 4'd5, 4'd6}; spn_y = '{5'd0, 5'd0, 5'd0, 5'd0}; end
    endcase
  end

  // ---------------------------------------------------------------------
  // Proposal datapath
  // ---------------------------------------------------------------------
  // Clockwise rotation about cell 1. Signed math so a cell that would land
  // above row 0 or left of column 0 is seen as out of range, which cancels
  // the whole rotation. The O piece never rotates.
  always_comb begin
    piv_x  = signed'({2'b00, cur_x[1]});
    piv_y  = signed'({1'b0, cur_y[1]});
    rot_ok = (block_type != 3'd2);
    for (int i = 0; i < 4; i++) begin
      rot_x[i] = piv_x - (signed'({1'b0, cur_y[i]}) - piv_y);
      rot_y[i] = piv_y + (signed'({2'b00, cur_x[i]}) - piv_x);
      if (rot_x[i] < 6'sd0 || rot_x[i] > 6'sd9 ||
          rot_y[i] < 6'sd0 || rot_y[i] > 6'sd19)
        rot_ok = 1'b0;
    end
  end

  always_comb begin
    at_left  = 1'b0;
    at_right = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cur_x[i] == 4'd0) at_left  = 1'b1;
      if (cur_x[i] == 4'd9) at_right = 1'b1;
    end
  end

  always_comb begin
    nxt_x = cur_x;
    nxt_y = cur_y;
    case (mv)
      // Row 20 is the floor; block_settling uses it to detect landing.
      MV_DOWN: for (int i = 0; i < 4; i++) nxt_y[i] = cur_y[i] + 5'd1;
      MV_LEFT: if (!at_left)
        for (int i = 0; i < 4; i++) nxt_x[i] = cur_x[i] - 4'd1;
      MV_RIGHT: if (!at_right)
        for (int i = 0; i < 4; i++) nxt_x[i] = cur_x[i] + 4'd1;
      MV_ROT: if (rot_ok)
        for (int i = 0; i < 4; i++) begin
          nxt_x[i] = rot_x[i][3:0];
          nxt_y[i] = rot_y[i][4:0];
        end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Committed piece state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_x      <= '{4'd0, 4'd0, 4'd0, 4'd0};
      cur_y      <= '{5'd0, 5'd0, 5'd0, 5'd0};
      block_type <= 3'd0;
      next_type  <= to_type(LFSR_SEED[2:0]);
    end else if (state == S_SPAWN) begin
      cur_x      <= spn_x;
      cur_y      <= spn_y;
      block_type <= next_type;
      next_type  <= cand_type;
    end else if (state == S_FALL && mv != MV_HOLD) begin
      cur_x <= chg_x;
      cur_y <= chg_y;
    end
  end

endmodule
